// File: rtl/interleave_seq_ctrl.sv
// Top-level control FSM for the interleave datapath: alternates LOAD and WRITE
// loop runs for a latched number of passes behind an ap_ctrl_chain interface.
module interleave_seq_ctrl #(
  parameter int unsigned PASS_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic              ap_continue,
  input  logic [PASS_W-1:0] num_passes,
  output logic              load_start,
  input  logic              load_ready,
  input  logic              load_done,
  output logic              write_start,
  input  logic              write_ready,
  input  logic              write_done,
  output logic [PASS_W-1:0] pass_idx,
  output logic [CNT_W-1:0]  load_cycles,
  output logic [CNT_W-1:0]  write_cycles,
  output logic [CNT_W-1:0]  total_cycles,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_RUN,
    S_WRITE_RUN,
    S_DONE_WAIT
  } state_e;

  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [PASS_W-1:0] npass_q, npass_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              lstart_q, lstart_d;
  logic              wstart_q, wstart_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              idle_q, idle_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  lcnt_q, lcnt_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic              accept;
  logic              viol;
  logic              last_pass;

  assign last_pass = ((pass_q + PASS_ONE) == npass_q);

  always_comb begin
    state_d  = state_q;
    npass_d  = npass_q;
    pass_d   = pass_q;
    lstart_d = lstart_q;
    wstart_d = wstart_q;
    ready_d  = 1'b0;
    accept   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          accept  = 1'b1;
          npass_d = num_passes;
          pass_d  = '0;
          ready_d = 1'b1;
          if (num_passes == '0) begin
            state_d = S_DONE_WAIT;
          end else begin
            state_d  = S_LOAD_RUN;
            lstart_d = 1'b1;
          end
        end
      end
      S_LOAD_RUN: begin
        // start drops on the first ready or done so the loop is never retriggered
        if (load_ready || load_done) lstart_d = 1'b0;
        if (load_done) begin
          state_d  = S_WRITE_RUN;
          wstart_d = 1'b1;
        end
      end
      S_WRITE_RUN: begin
        if (write_ready || write_done) wstart_d = 1'b0;
        if (write_done) begin
          if (last_pass) begin
            state_d = S_DONE_WAIT;
          end else begin
            pass_d   = pass_q + PASS_ONE;
            state_d  = S_LOAD_RUN;
            lstart_d = 1'b1;
          end
        end
      end
      S_DONE_WAIT: begin
        if (ap_continue) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE_WAIT);
    idle_d = (state_d == S_IDLE);

    lcnt_d = lcnt_q;
    wcnt_d = wcnt_q;
    tcnt_d = tcnt_q;
    if (accept) begin
      lcnt_d = '0;
      wcnt_d = '0;
      tcnt_d = '0;
    end else begin
      if (state_q == S_LOAD_RUN && lcnt_q != '1)  lcnt_d = lcnt_q + CNT_ONE;
      if (state_q == S_WRITE_RUN && wcnt_q != '1) wcnt_d = wcnt_q + CNT_ONE;
      if (state_q != S_IDLE && tcnt_q != '1)      tcnt_d = tcnt_q + CNT_ONE;
    end

    // continue is tolerated in IDLE and DONE_WAIT, flagged only mid-run
    viol = ((load_ready || load_done) && state_q != S_LOAD_RUN) ||
           ((write_ready || write_done) && state_q != S_WRITE_RUN) ||
           (ap_continue && (state_q == S_LOAD_RUN || state_q == S_WRITE_RUN));
    err_d = accept ? 1'b0 : err_q;
    if (viol) err_d = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      npass_q  <= '0;
      pass_q   <= '0;
      lstart_q <= 1'b0;
      wstart_q <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
      err_q    <= 1'b0;
      lcnt_q   <= '0;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      npass_q  <= npass_d;
      pass_q   <= pass_d;
      lstart_q <= lstart_d;
      wstart_q <= wstart_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      lcnt_q   <= lcnt_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign ap_ready     = ready_q;
  assign ap_done      = done_q;
  assign ap_idle      = idle_q;
  assign load_start   = lstart_q;
  assign write_start  = wstart_q;
  assign pass_idx     = pass_q;
  assign load_cycles  = lcnt_q;
  assign write_cycles = wcnt_q;
  assign total_cycles = tcnt_q;
  assign proto_err    = err_q;

endmodule
